// File: rtl/exc_ctrl.sv
// Exception-entry sequencer: arbitrates SWI/FIQ/IRQ at instruction boundaries
// and drives the three-cycle entry (save LR/SPSR, switch mode, load vector).
// Optional feature macro: IRQ_SYNC_EN adds 2-flop synchronizers on irq/firq.
module exc_ctrl #(
  parameter logic [31:0] VEC_BASE = 32'h0000_0000,
  parameter logic [31:0] SWI_OFS  = 32'h0000_0008,
  parameter logic [31:0] IRQ_OFS  = 32'h0000_0018,
  parameter logic [31:0] FIQ_OFS  = 32'h0000_001C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq,
  input  logic        firq,
  input  logic        swi_req,
  input  logic        instr_done,
  input  logic [31:0] pc_in,
  input  logic [31:0] cpsr_in,
  output logic        stall,
  output logic        lr_we,
  output logic [31:0] lr_data,
  output logic        spsr_we,
  output logic [31:0] spsr_data,
  output logic        mode_we,
  output logic [4:0]  mode_out,
  output logic        set_i,
  output logic        set_f,
  output logic        pc_load,
  output logic [31:0] pc_vector,
  output logic [1:0]  exc_cause
);

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_SWI  = 2'b01;
  localparam logic [1:0] CAUSE_IRQ  = 2'b10;
  localparam logic [1:0] CAUSE_FIQ  = 2'b11;

  localparam logic [4:0] MODE_FIQ = 5'h11;
  localparam logic [4:0] MODE_IRQ = 5'h12;
  localparam logic [4:0] MODE_SVC = 5'h13;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAVE   = 2'd1,
    SWITCH = 2'd2,
    VECTOR = 2'd3
  } state_t;

  state_t     state;
  logic       irq_q;
  logic       firq_q;
  logic [1:0] dec;

`ifdef IRQ_SYNC_EN
  logic [1:0] irq_sync;
  logic [1:0] firq_sync;

  // Two-flop synchronizers for the asynchronous interrupt pins
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_sync  <= 2'b00;
      firq_sync <= 2'b00;
    end else begin
      irq_sync  <= {irq_sync[0], irq};
      firq_sync <= {firq_sync[0], firq};
    end
  end

  assign irq_q  = irq_sync[1];
  assign firq_q = firq_sync[1];
`else
  assign irq_q  = irq;
  assign firq_q = firq;
`endif

  // Boundary arbitration: SWI belongs to the retiring instruction, then FIQ, then IRQ
  always_comb begin
    dec = CAUSE_NONE;
    if (swi_req) begin
      dec = CAUSE_SWI;
    end else if (firq_q && !cpsr_in[6]) begin
      dec = CAUSE_FIQ;
    end else if (irq_q && !cpsr_in[7]) begin
      dec = CAUSE_IRQ;
    end
  end

  // Entry sequencer; outputs are registered alongside the state they belong to
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      stall     <= 1'b0;
      lr_we     <= 1'b0;
      lr_data   <= 32'h0;
      spsr_we   <= 1'b0;
      spsr_data <= 32'h0;
      mode_we   <= 1'b0;
      mode_out  <= 5'h0;
      set_i     <= 1'b0;
      set_f     <= 1'b0;
      pc_load   <= 1'b0;
      pc_vector <= 32'h0;
      exc_cause <= CAUSE_NONE;
    end else begin
      stall     <= 1'b0;
      lr_we     <= 1'b0;
      lr_data   <= 32'h0;
      spsr_we   <= 1'b0;
      spsr_data <= 32'h0;
      mode_we   <= 1'b0;
      mode_out  <= 5'h0;
      set_i     <= 1'b0;
      set_f     <= 1'b0;
      pc_load   <= 1'b0;
      pc_vector <= 32'h0;
      case (state)
        IDLE: begin
          if (instr_done && (dec != CAUSE_NONE)) begin
            state     <= SAVE;
            stall     <= 1'b1;
            lr_we     <= 1'b1;
            spsr_we   <= 1'b1;
            lr_data   <= pc_in + ((dec == CAUSE_SWI) ? 32'd4 : 32'd8);
            spsr_data <= cpsr_in;
            exc_cause <= dec;
          end
        end
        SAVE: begin
          state   <= SWITCH;
          stall   <= 1'b1;
          mode_we <= 1'b1;
          set_i   <= 1'b1;
          set_f   <= (exc_cause == CAUSE_FIQ);
          case (exc_cause)
            CAUSE_FIQ: mode_out <= MODE_FIQ;
            CAUSE_IRQ: mode_out <= MODE_IRQ;
            default:   mode_out <= MODE_SVC;
          endcase
        end
        SWITCH: begin
          state   <= VECTOR;
          stall   <= 1'b1;
          pc_load <= 1'b1;
          case (exc_cause)
            CAUSE_FIQ: pc_vector <= VEC_BASE + FIQ_OFS;
            CAUSE_IRQ: pc_vector <= VEC_BASE + IRQ_OFS;
            default:   pc_vector <= VEC_BASE + SWI_OFS;
          endcase
        end
        VECTOR: begin
          state     <= IDLE;
          exc_cause <= CAUSE_NONE;
        end
        default: begin
          state     <= IDLE;
          exc_cause <= CAUSE_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: stimulus pushes expected entry-sequence
// records, a negedge monitor pops one per stalled cycle and compares.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq;
  logic        firq;
  logic        swi_req;
  logic        instr_done;
  logic [31:0] pc_in;
  logic [31:0] cpsr_in;
  logic        stall;
  logic        lr_we;
  logic [31:0] lr_data;
  logic        spsr_we;
  logic [31:0] spsr_data;
  logic        mode_we;
  logic [4:0]  mode_out;
  logic        set_i;
  logic        set_f;
  logic        pc_load;
  logic [31:0] pc_vector;
  logic [1:0]  exc_cause;

  exc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .firq       (firq),
    .swi_req    (swi_req),
    .instr_done (instr_done),
    .pc_in      (pc_in),
    .cpsr_in    (cpsr_in),
    .stall      (stall),
    .lr_we      (lr_we),
    .lr_data    (lr_data),
    .spsr_we    (spsr_we),
    .spsr_data  (spsr_data),
    .mode_we    (mode_we),
    .mode_out   (mode_out),
    .set_i      (set_i),
    .set_f      (set_f),
    .pc_load    (pc_load),
    .pc_vector  (pc_vector),
    .exc_cause  (exc_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        lr_we;
    logic        spsr_we;
    logic        mode_we;
    logic        set_i;
    logic        set_f;
    logic        pc_load;
    logic [4:0]  mode_out;
    logic [1:0]  exc_cause;
    logic [31:0] lr_data;
    logic [31:0] spsr_data;
    logic [31:0] pc_vector;
  } obs_t;

  typedef struct packed {
    obs_t exp;
    obs_t mask;
  } rec_t;

  obs_t obs;
  rec_t sb[$];
  rec_t cur;
  int   vectors = 0;
  int   miscompares = 0;
  logic mon_en = 1'b0;

  always_comb begin
    obs           = '0;
    obs.stall     = stall;
    obs.lr_we     = lr_we;
    obs.spsr_we   = spsr_we;
    obs.mode_we   = mode_we;
    obs.set_i     = set_i;
    obs.set_f     = set_f;
    obs.pc_load   = pc_load;
    obs.mode_out  = mode_out;
    obs.exc_cause = exc_cause;
    obs.lr_data   = lr_data;
    obs.spsr_data = spsr_data;
    obs.pc_vector = pc_vector;
  end

  task automatic chk(input string name, input obs_t act, input obs_t exp, input obs_t mask);
    logic [$bits(obs_t)-1:0] a;
    logic [$bits(obs_t)-1:0] e;
    a = act & mask;
    e = exp & mask;
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h want %h (mask %h)", name, $time, a, e, mask);
    end
  endtask

  function automatic obs_t strobe_mask();
    obs_t m;
    m = '0;
    m.stall   = 1'b1;
    m.lr_we   = 1'b1;
    m.spsr_we = 1'b1;
    m.mode_we = 1'b1;
    m.pc_load = 1'b1;
    return m;
  endfunction

  // Queue the expected SAVE/SWITCH/VECTOR records (nph of them) for one entry
  task automatic push_entry(input logic [1:0] cause, input logic [31:0] lr,
                            input logic [31:0] spsr, input logic [4:0] mode,
                            input logic sf, input logic [31:0] vec, input int nph);
    rec_t r;
    for (int ph = 0; ph < nph; ph++) begin
      r.exp  = '0;
      r.mask = strobe_mask();
      r.mask.exc_cause = '1;
      r.exp.stall      = 1'b1;
      r.exp.exc_cause  = cause;
      if (ph == 0) begin
        r.exp.lr_we      = 1'b1;
        r.exp.spsr_we    = 1'b1;
        r.exp.lr_data    = lr;
        r.exp.spsr_data  = spsr;
        r.mask.lr_data   = '1;
        r.mask.spsr_data = '1;
      end else if (ph == 1) begin
        r.exp.mode_we   = 1'b1;
        r.exp.mode_out  = mode;
        r.exp.set_i     = 1'b1;
        r.exp.set_f     = sf;
        r.mask.mode_out = '1;
        r.mask.set_i    = 1'b1;
        r.mask.set_f    = 1'b1;
      end else begin
        r.exp.pc_load    = 1'b1;
        r.exp.pc_vector  = vec;
        r.mask.pc_vector = '1;
      end
      sb.push_back(r);
    end
  endtask

  task automatic boundary(input logic swi, input logic [31:0] pc, input logic [31:0] cpsr);
    @(posedge clk); #1;
    instr_done = 1'b1;
    swi_req    = swi;
    pc_in      = pc;
    cpsr_in    = cpsr;
    @(posedge clk); #1;
    instr_done = 1'b0;
    swi_req    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: each stalled cycle consumes one expected record; idle cycles must be quiet
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_stall @%0t: got stall=1 with no entry expected", $time);
        end else begin
          cur = sb.pop_front();
          chk("entry_phase", obs, cur.exp, cur.mask);
        end
      end else begin
        chk("idle_strobes", obs, '0, strobe_mask());
      end
    end
  end

  initial begin
    reset = 1'b1; irq = 1'b0; firq = 1'b0; swi_req = 1'b0;
    instr_done = 1'b0; pc_in = 32'h0; cpsr_in = 32'h10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", obs, '0, '1);
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // SWI from user mode
    push_entry(2'b01, 32'h104, 32'h10, 5'h13, 1'b0, 32'h08, 3);
    boundary(1'b1, 32'h100, 32'h10);
    idle(4);

    // IRQ, then IRQ with LR wrap, plus an instr_done during the sequence
    irq = 1'b1;
    idle(2);
    push_entry(2'b10, 32'h208, 32'h10, 5'h12, 1'b0, 32'h18, 3);
    boundary(1'b0, 32'h200, 32'h10);
    idle(4);
    push_entry(2'b10, 32'h4, 32'h10, 5'h12, 1'b0, 32'h18, 3);
    boundary(1'b0, 32'hFFFF_FFFC, 32'h10);
    boundary(1'b0, 32'h300, 32'h10);
    irq = 1'b0;
    idle(4);

    // FIQ beats IRQ; then both masked -> nothing
    irq = 1'b1; firq = 1'b1;
    idle(2);
    push_entry(2'b11, 32'h408, 32'h10, 5'h11, 1'b1, 32'h1C, 3);
    boundary(1'b0, 32'h400, 32'h10);
    idle(4);
    boundary(1'b0, 32'h404, 32'hD1);
    idle(2);
    firq = 1'b0;

    // Masked IRQ over five boundaries, then unmasked
    for (int i = 0; i < 5; i++) begin
      boundary(1'b0, 32'h500 + 32'(4 * i), 32'h90);
      idle(1);
    end
    push_entry(2'b10, 32'h608, 32'h10, 5'h12, 1'b0, 32'h18, 3);
    boundary(1'b0, 32'h600, 32'h10);
    idle(4);
    irq = 1'b0;

    // SWI wins over FIQ, FIQ follows at the next boundary
    firq = 1'b1;
    idle(2);
    push_entry(2'b01, 32'h704, 32'h10, 5'h13, 1'b0, 32'h08, 3);
    boundary(1'b1, 32'h700, 32'h10);
    idle(4);
    push_entry(2'b11, 32'h70C, 32'h93, 5'h11, 1'b1, 32'h1C, 3);
    boundary(1'b0, 32'h704, 32'h93);
    idle(4);
    firq = 1'b0;
    idle(2);

    // Reset while in SWITCH aborts the entry
    push_entry(2'b01, 32'h804, 32'h10, 5'h13, 1'b0, 32'h08, 2);
    boundary(1'b1, 32'h800, 32'h10);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_in_switch", obs, '0, '1);
    boundary(1'b0, 32'h900, 32'h10);
    idle(5);

    // All expected records must have been consumed
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d records left, want 0", sb.size());
    end
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
